// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with byte FIFO and DATA/STATUS register reads
//
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   addr     - register select, only addr[2] decoded (0 = DATA, 1 = STATUS)
//   din      - write data (no writable registers, ignored)
//   dout     - registered read data, valid for one cycle after the access
//   wr       - 1 = write, 0 = read, qualified by valid
//   valid    - single-cycle bus access strobe
//   rxd      - asynchronous serial input, idle high, LSB first
module uart_rx #(
  parameter int BIT_TIME   = 433,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        valid,
  input  logic        rxd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0]   CNT_FULL  = 12'(BIT_TIME);
  localparam logic [11:0]   CNT_HALF  = 12'(BIT_TIME / 2);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_n;
  logic [11:0]   cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, fe_set;
  logic          rxd_meta, rxd_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          oe, fe;

  logic          rd_data, rd_stat, pop, full, push_ok, oe_set;
  logic [4:0]    count_ext;
  logic [31:0]   status;
  logic          unused_ok;

  assign unused_ok = ^{din, addr[1:0]};

  // Two-flop synchronizer; resets to the idle line level so no false start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high level means a glitch.
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!rxd_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          shreg_n = {rxd_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_data = valid && !wr && !addr[2];
  assign rd_stat = valid && !wr && addr[2];
  assign pop     = rd_data && (count != '0);
  assign full    = (count == DEPTH_CNT);
  // A pop on the same edge frees the slot, so a push into a full FIFO still fits.
  assign push_ok = push && (!full || pop);
  assign oe_set  = push && full && !pop;

  assign count_ext = 5'(count);
  assign status    = {20'b0, count_ext[3:0], 4'b0, fe, 1'b0, oe, (count != '0)};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      oe    <= 1'b0;
      fe    <= 1'b0;
      dout  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (pop && !push_ok) count <= count - CNT_ONE;
      // Set wins over the clear-on-read of STATUS.
      oe <= oe_set | (oe & ~rd_stat);
      fe <= fe_set | (fe & ~rd_stat);
      if (rd_data)      dout <= (count != '0) ? {24'b0, mem[rptr]} : 32'b0;
      else if (rd_stat) dout <= status;
      else              dout <= 32'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BT_P  = 15;
  localparam int BT    = BT_P + 1;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        wr;
  logic        valid;
  logic        rxd;

  int errors = 0;
  int checks = 0;

  byte unsigned mq[$];
  bit m_oe, m_fe;

  typedef struct {
    logic [7:0]  data;
    bit          stop;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  uart_rx #(.BIT_TIME(BT_P), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .wr(wr), .valid(valid), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n = mq.size();
    return {20'b0, 4'(n), 4'b0, m_fe, 1'b0, m_oe, (n != 0)};
  endfunction

  // Assumes the caller is at a falling edge; returns at a falling edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BT) @(negedge clk);
    end
    rxd = stop;
    repeat (BT) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_oe = 1'b1;
  endtask

  task automatic bus_read(input bit a2, output logic [31:0] d);
    @(negedge clk);
    addr  = {a2, 2'b00};
    wr    = 1'b0;
    valid = 1'b1;
    @(posedge clk);
    #1 d = dout;
    valid = 1'b0;
  endtask

  task automatic read_check_status(input string name);
    logic [31:0] d;
    bus_read(1'b1, d);
    check(name, d, model_status());
    m_oe = 1'b0;
    m_fe = 1'b0;
  endtask

  task automatic read_check_data(input string name);
    logic [31:0] d, e;
    e = (mq.size() != 0) ? {24'b0, mq.pop_front()} : 32'b0;
    bus_read(1'b0, d);
    check(name, d, e);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rb;
    bit          rs;
    int          nr;

    vecs[0] = '{8'h55, 1'b1, 32'h0000_0101, 32'h0000_0055};
    vecs[1] = '{8'h00, 1'b1, 32'h0000_0101, 32'h0000_0000};
    vecs[2] = '{8'hFF, 1'b1, 32'h0000_0101, 32'h0000_00FF};
    vecs[3] = '{8'hA5, 1'b0, 32'h0000_0008, 32'h0000_0000};
    vecs[4] = '{8'h80, 1'b1, 32'h0000_0101, 32'h0000_0080};
    vecs[5] = '{8'h3C, 1'b1, 32'h0000_0101, 32'h0000_003C};

    reset_n = 1'b0;
    rxd     = 1'b1;
    addr    = '0;
    din     = '0;
    wr      = 1'b0;
    valid   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(1'b1, d);
    check("reset_status", d, 32'h0);

    // Table-driven frames: each frame then STATUS, DATA, STATUS.
    foreach (vecs[i]) begin
      @(negedge clk);
      send_frame(vecs[i].data, vecs[i].stop);
      bus_read(1'b1, d);
      check($sformatf("vec%0d_status", i), d, vecs[i].exp_status);
      bus_read(1'b0, d);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      bus_read(1'b1, d);
      check($sformatf("vec%0d_status2", i), d, 32'h0);
    end

    // dout lasts one cycle; a write returns 0 and leaves the FIFO alone.
    @(negedge clk);
    send_frame(8'hC3, 1'b1);
    bus_read(1'b1, d);
    check("wr_pre_status", d, 32'h0000_0101);
    @(negedge clk);
    addr = 3'b000; wr = 1'b1; valid = 1'b1; din = $urandom;
    @(posedge clk);
    #1 check("wr_dout_zero", dout, 32'h0);
    valid = 1'b0; wr = 1'b0;
    bus_read(1'b0, d);
    check("wr_no_effect", d, 32'h0000_00C3);
    @(posedge clk);
    #1 check("dout_one_cycle", dout, 32'h0);

    // Glitch shorter than half a bit is rejected.
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BT) @(negedge clk);
    bus_read(1'b1, d);
    check("glitch_status", d, 32'h0);
    @(negedge clk);
    send_frame(8'h3C, 1'b1);
    bus_read(1'b0, d);
    check("glitch_then_data", d, 32'h0000_003C);

    // Overflow: 9 bytes with no reads.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      send_frame(8'(i), 1'b1);
    end
    bus_read(1'b1, d);
    check("ovf_status", d, 32'h0000_0803);
    for (int i = 1; i <= 8; i++) begin
      bus_read(1'b0, d);
      check($sformatf("ovf_data%0d", i), d, 32'(i));
    end
    bus_read(1'b1, d);
    check("ovf_drained", d, 32'h0);

    // Stop bit low followed by a long break.
    @(negedge clk);
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rb  = 8'hA5;
      rxd = rb[i];
      repeat (BT) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (20 * BT) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(1'b1, d);
    check("break_status", d, 32'h0000_0008);
    @(negedge clk);
    send_frame(8'h3C, 1'b1);
    bus_read(1'b1, d);
    check("break_recover_status", d, 32'h0000_0101);
    bus_read(1'b0, d);
    check("break_recover_data", d, 32'h0000_003C);

    // Reset during data bit 4 with one byte already queued.
    @(negedge clk);
    send_frame(8'h11, 1'b1);
    rb  = 8'h99;
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      repeat (BT) @(negedge clk);
    end
    rxd = rb[4];
    repeat (BT / 2) @(negedge clk);
    reset_n = 1'b0;
    #1 check("midreset_dout", dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rxd = 1'b1;
    repeat (2 * BT) @(negedge clk);
    bus_read(1'b1, d);
    check("midreset_status", d, 32'h0);
    @(negedge clk);
    send_frame(8'h7E, 1'b1);
    bus_read(1'b1, d);
    check("midreset_next_status", d, 32'h0000_0101);
    bus_read(1'b0, d);
    check("midreset_next_data", d, 32'h0000_007E);

    // Full FIFO: DATA read lands on the stop-sample edge of a new byte.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      send_frame(8'h21 + 8'(i), 1'b1);
    end
    @(negedge clk);
    fork
      send_frame(8'h29, 1'b1);
      begin
        // Stop sample falls on the 155th rising edge after rxd drops:
        // 2 sync + 1 idle + 8 start half + 9 x BT.
        repeat (2 + 1 + (BT_P / 2 + 1) + 9 * BT - 1) @(posedge clk);
        @(negedge clk);
        addr = 3'b000; wr = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1 check("full_poppush_data", dout, 32'h0000_0021);
        valid = 1'b0;
      end
    join
    bus_read(1'b1, d);
    check("full_poppush_status", d, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      bus_read(1'b0, d);
      check($sformatf("full_poppush_drain%0d", i), d, 32'h22 + 32'(i));
    end

    // Randomized frames and reads against the queue model.
    mq.delete();
    m_oe = 1'b0;
    m_fe = 1'b0;
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      send_frame(rb, rs);
      model_frame(rb, rs);
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) read_check_data($sformatf("rnd%0d_data%0d", n, k));
      if ($urandom_range(0, 2) == 0) read_check_status($sformatf("rnd%0d_status", n));
    end
    read_check_status("rnd_final_status");
    while (mq.size() != 0) read_check_data("rnd_drain");
    read_check_status("rnd_empty_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
